calc_op_sequencer: RTL and testbench
====================================

Name: calc_op_sequencer

Overview:
- Control FSM for the calculator datapath inside tt_um_calculator.
- Collects operand A, opcode and operand B from the 8-bit switch bus, one key press per field.
- Launches the iterative calculator ALU with a start pulse, waits for its done, and latches the 16-bit result for display.
- Rejects illegal opcodes and divide-by-zero before launch; guards the ALU with a timeout watchdog.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the key-input synchronizer (min 2).
- TIMEOUT, 64, maximum cycles spent in WAIT before declaring an ALU fault.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; when low, key events are ignored
- din  input  8  switch bus: operand value or opcode (din[2:0])
- key  input  1  raw asynchronous entry button, active high
- clr  input  1  synchronous clear, highest priority
- alu_start  output  1  one-cycle launch pulse to the ALU
- alu_op  output  3  opcode presented to the ALU
- alu_a  output  8  operand A to the ALU
- alu_b  output  8  operand B to the ALU
- alu_done  input  1  ALU completion strobe, one cycle
- alu_result  input  16  ALU result, valid when alu_done=1
- alu_err  input  1  ALU fault flag, valid when alu_done=1
- result  output  16  latched display value
- state  output  3  current FSM state encoding
- busy  output  1  high in EXEC or WAIT
- err_code  output  2  0 none, 1 illegal opcode, 2 divide by zero, 3 ALU fault or timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE, result=0, err_code=0, alu_start=0, alu_op=0, alu_a=0, alu_b=0, busy=0, timeout counter=0, synchronizer and edge registers=0.
- Key event:
  - key passes through SYNC_STAGES flops, then a rising-edge detector.
  - An event is one cycle wide and is qualified by ena=1.
  - A pin going high before clock edge k produces the FSM update at edge k+SYNC_STAGES+1.
  - Holding key high yields exactly one event.
- State encoding: IDLE=0, GET_OP=1, GET_B=2, EXEC=3, WAIT=4, SHOW=5, ERR=6.
- IDLE: on event, alu_a<=din, go to GET_OP.
- GET_OP: on event, alu_op<=din[2:0].
  - If din[2:0] is 6 or 7, go to ERR with err_code=1.
  - Otherwise go to GET_B.
  - din[7:3] is ignored.
- GET_B: on event, alu_b<=din.
  - If alu_op is 3 (DIV) or 4 (MOD) and din=0, go to ERR with err_code=2; no start is issued.
  - Otherwise go to EXEC.
- EXEC: alu_start=1 for exactly this one cycle, timeout counter<=0, then go to WAIT.
- WAIT: counter increments each cycle.
  - On alu_done with alu_err=0: result<=alu_result, go to SHOW.
  - On alu_done with alu_err=1: go to ERR with err_code=3.
  - If the counter reaches TIMEOUT-1 without done: go to ERR with err_code=3.
  - alu_done and timeout in the same cycle: done wins.
- SHOW: result is held; err_code=0. On event, alu_a<=din and go to GET_OP to start a new calculation.
- ERR: result<=0 on entry. On event, go to IDLE and clear err_code; din is discarded.
- alu_op, alu_a and alu_b are stable from EXEC until WAIT is exited.
- alu_done outside WAIT is ignored.
- ena=0 ignores key events only; EXEC and WAIT continue to run.
- clr=1: next state is IDLE, with result=0 and err_code=0.
  - clr beats a simultaneous key event or alu_done.
  - clr during WAIT abandons the operation; a late alu_done is ignored.
- busy is combinational from state.

Test Plan:
- Press keys with din=0x0C, then 0x00 (ADD), then 0x22; ALU returns 0x002E -> alu_start pulses once, result=0x002E, state=5, err_code=0.
- Enter opcode din=0x07 -> state=6, err_code=1, alu_start never asserted; next key press -> state=0, err_code=0.
- Enter A=0x40, op=3, B=0x00 -> err_code=2, no alu_start, result=0.
- Launch an ADD and never assert alu_done -> state=6 and err_code=3 exactly TIMEOUT cycles after the alu_start pulse.
- Assert clr in WAIT, then pulse alu_done with alu_result=0x1234 two cycles later -> state=0 and result=0 are retained.
- Hold key high for 20 cycles with ena=1 -> only one field is captured; pulse key with ena=0 -> no state change; pulse key for 1 cycle in SHOW with din=0x05 -> alu_a=0x05, state=1.

Source files
------------

// File: rtl/calc_op_sequencer.sv
// Calculator control FSM: collects A / opcode / B via key presses, launches the ALU,
// waits for done (with watchdog) and latches the 16-bit result or an error code.
module calc_op_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  din,
  input  logic        key,
  input  logic        clr,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic        alu_err,
  output logic [15:0] result,
  output logic [2:0]  state,
  output logic        busy,
  output logic [1:0]  err_code
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_DIV0    = 2'd2;
  localparam logic [1:0] ERR_ALU     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GET_OP = 3'd1,
    S_GET_B  = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_SHOW   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_key_d;
  logic                   r_evt;
  logic                   w_evt;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_a, w_a_nxt;
  logic [7:0]  r_b, w_b_nxt;
  logic [2:0]  r_op, w_op_nxt;
  logic [15:0] r_res, w_res_nxt;
  logic [1:0]  r_err, w_err_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  // Synchronizer, then a registered rising-edge pulse so a held key yields one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_key_d <= 1'b0;
      r_evt   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], key};
      r_key_d <= r_sync[SYNC_STAGES-1];
      r_evt   <= r_sync[SYNC_STAGES-1] & ~r_key_d;
    end
  end

  assign w_evt = r_evt & ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_err   <= ERR_NONE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_res   <= w_res_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_res_nxt   = r_res;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_evt) begin
          w_a_nxt     = din;
          w_state_nxt = S_GET_OP;
        end
      end
      S_GET_OP: begin
        if (w_evt) begin
          w_op_nxt = din[2:0];
          if (din[2:1] == 2'b11) begin
            w_err_nxt   = ERR_ILLEGAL;
            w_res_nxt   = '0;
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_GET_B;
          end
        end
      end
      S_GET_B: begin
        if (w_evt) begin
          w_b_nxt = din;
          if ((r_op == 3'd3 || r_op == 3'd4) && din == 8'd0) begin
            w_err_nxt   = ERR_DIV0;
            w_res_nxt   = '0;
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last watchdog cycle still counts.
        if (alu_done) begin
          if (alu_err) begin
            w_err_nxt   = ERR_ALU;
            w_res_nxt   = '0;
            w_state_nxt = S_ERR;
          end else begin
            w_err_nxt   = ERR_NONE;
            w_res_nxt   = alu_result;
            w_state_nxt = S_SHOW;
          end
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_err_nxt   = ERR_ALU;
          w_res_nxt   = '0;
          w_state_nxt = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_SHOW: begin
        w_err_nxt = ERR_NONE;
        if (w_evt) begin
          w_a_nxt     = din;
          w_state_nxt = S_GET_OP;
        end
      end
      S_ERR: begin
        if (w_evt) begin
          w_err_nxt   = ERR_NONE;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (clr) begin
      w_state_nxt = S_IDLE;
      w_res_nxt   = '0;
      w_err_nxt   = ERR_NONE;
    end
  end

  assign alu_start = (r_state == S_EXEC);
  assign busy      = (r_state == S_EXEC) || (r_state == S_WAIT);
  assign alu_op    = r_op;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign result    = r_res;
  assign err_code  = r_err;
  assign state     = r_state;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed and randomized checks of calc_op_sequencer against a field-level calculator model.
module tb_calc_op_sequencer;

  localparam int SYNC = 2;
  localparam int TO   = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  din;
  logic        key;
  logic        clr;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_err;
  logic [15:0] result;
  logic [2:0]  state;
  logic        busy;
  logic [1:0]  err_code;

  int checks   = 0;
  int failures = 0;
  int n_start  = 0;

  calc_op_sequencer #(.SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .key(key), .clr(clr),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .result(result), .state(state), .busy(busy), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (alu_start === 1'b1) n_start++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Key low gap, then a press held until the FSM has consumed it.
  task automatic press(input logic [7:0] v);
    repeat (SYNC + 1) tick();
    din = v;
    key = 1'b1;
    repeat (SYNC + 2) tick();
    key = 1'b0;
  endtask

  // Acts as the ALU: done arrives with the watchdog counter at value d.
  task automatic respond(input int d, input logic [15:0] r, input logic e);
    tick();
    repeat (d) tick();
    alu_done   = 1'b1;
    alu_result = r;
    alu_err    = e;
    tick();
    alu_done   = 1'b0;
    alu_err    = 1'b0;
  endtask

  int          ns0;
  int          d;
  logic [7:0]  ra, rb;
  logic [2:0]  rop;
  logic [15:0] rr;
  logic        re;
  logic [15:0] exp_res;

  initial begin
    rst_n = 1'b0; ena = 1'b1; din = '0; key = 1'b0; clr = 1'b0;
    alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err_code, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops", {alu_op, alu_a, alu_b}, 0);
    rst_n = 1'b1;
    tick();

    // Basic ADD 0x0C + 0x22
    ns0 = n_start;
    press(8'h0C); chk("add_a_state", state, 1); chk("add_a_val", alu_a, 8'h0C);
    press(8'h00); chk("add_op_state", state, 2);
    press(8'h22); chk("add_exec", state, 3); chk("add_start", alu_start, 1); chk("add_busy", busy, 1);
    chk("add_ops", {alu_op, alu_a, alu_b}, {3'd0, 8'h0C, 8'h22});
    respond(2, 16'h002E, 1'b0);
    chk("add_state", state, 5); chk("add_result", result, 16'h002E); chk("add_err", err_code, 0);
    chk("add_nstart", n_start - ns0, 1);

    // clr during WAIT; later done ignored
    press(8'h01); chk("clr_a", state, 1); chk("clr_res_held", result, 16'h002E);
    press(8'h00);
    press(8'h02); chk("clr_exec", state, 3);
    tick(); chk("clr_wait", state, 4);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_state", state, 0); chk("clr_result", result, 0);
    tick(); tick();
    alu_done = 1'b1; alu_result = 16'h1234; tick(); alu_done = 1'b0;
    tick();
    chk("clr_late_state", state, 0); chk("clr_late_result", result, 0);

    // Illegal opcode
    ns0 = n_start;
    press(8'h01);
    press(8'h07);
    chk("ill_state", state, 6); chk("ill_err", err_code, 1); chk("ill_result", result, 0);
    repeat (4) tick(); chk("ill_nstart", n_start - ns0, 0);
    press(8'h99); chk("ill_clr_state", state, 0); chk("ill_clr_err", err_code, 0);

    // Divide by zero
    press(8'h40); press(8'h03); press(8'h00);
    chk("dz_state", state, 6); chk("dz_err", err_code, 2); chk("dz_result", result, 0);
    repeat (4) tick(); chk("dz_nstart", n_start - ns0, 0);
    press(8'h00); chk("dz_clr", state, 0);

    // Watchdog: no done
    press(8'h01); press(8'h00); press(8'h02);
    chk("to_exec", state, 3);
    repeat (TO) tick();
    chk("to_still_wait", state, 4); chk("to_busy", busy, 1);
    tick();
    chk("to_state", state, 6); chk("to_err", err_code, 3); chk("to_busy_off", busy, 0);
    press(8'h00); chk("to_clr", state, 0);

    // Done on the final watchdog cycle wins
    press(8'h03); press(8'h02); press(8'h04);
    respond(TO - 1, 16'hBEEF, 1'b0);
    chk("dw_state", state, 5); chk("dw_result", result, 16'hBEEF); chk("dw_err", err_code, 0);

    // ALU fault
    press(8'h03); press(8'h01); press(8'h01);
    respond(3, 16'h5555, 1'b1);
    chk("af_state", state, 6); chk("af_err", err_code, 3); chk("af_result", result, 0);
    press(8'h00); chk("af_clr", state, 0);

    // Held key yields one event; ena=0 drops events but not WAIT
    repeat (SYNC + 1) tick();
    din = 8'h11; key = 1'b1;
    repeat (20) tick();
    key = 1'b0;
    repeat (4) tick();
    chk("hold_state", state, 1); chk("hold_a", alu_a, 8'h11);
    ena = 1'b0;
    press(8'h01); repeat (3) tick();
    chk("ena0_state", state, 1);
    ena = 1'b1;
    press(8'h00); press(8'h01);
    chk("ena_exec", state, 3);
    ena = 1'b0;
    respond(5, 16'h0012, 1'b0);
    chk("ena0_wait_state", state, 5); chk("ena0_wait_res", result, 16'h0012);
    ena = 1'b1;
    press(8'h05);
    chk("show_a_state", state, 1); chk("show_a_val", alu_a, 8'h05);
    press(8'h00); press(8'h00);
    respond(0, 16'h0005, 1'b0);
    chk("show_chain", state, 5);
    exp_res = 16'h0005;

    // Randomized calculations vs field-level model
    for (int it = 0; it < 30; it++) begin
      ra  = 8'($urandom);
      rop = 3'($urandom_range(0, 7));
      rb  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      ns0 = n_start;
      press(ra);
      chk("r_a_state", state, 1); chk("r_a_val", alu_a, ra); chk("r_a_res", result, exp_res);
      press({5'($urandom), rop});
      if (rop >= 3'd6) begin
        exp_res = 16'h0;
        chk("r_ill_state", state, 6); chk("r_ill_err", err_code, 1); chk("r_ill_res", result, exp_res);
        press(8'($urandom)); chk("r_ill_idle", state, 0);
        chk("r_ill_nstart", n_start - ns0, 0);
        continue;
      end
      chk("r_op_state", state, 2);
      press(rb);
      if ((rop == 3'd3 || rop == 3'd4) && rb == 8'h00) begin
        exp_res = 16'h0;
        chk("r_dz_state", state, 6); chk("r_dz_err", err_code, 2); chk("r_dz_res", result, exp_res);
        press(8'($urandom)); chk("r_dz_idle", state, 0);
        chk("r_dz_nstart", n_start - ns0, 0);
        continue;
      end
      chk("r_exec", alu_start, 1);
      chk("r_ops", {alu_op, alu_a, alu_b}, {rop, ra, rb});
      d  = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 8);
      re = ($urandom_range(0, 4) == 0);
      rr = 16'($urandom);
      respond(d, rr, re);
      chk("r_nstart", n_start - ns0, 1);
      chk("r_ops_hold", {alu_op, alu_a, alu_b}, {rop, ra, rb});
      if (d < TO && !re) begin
        exp_res = rr;
        chk("r_show_state", state, 5); chk("r_show_res", result, exp_res); chk("r_show_err", err_code, 0);
      end else begin
        exp_res = 16'h0;
        chk("r_fault_state", state, 6); chk("r_fault_err", err_code, 3); chk("r_fault_res", result, exp_res);
        press(8'($urandom)); chk("r_fault_idle", state, 0); chk("r_fault_clr", err_code, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
